// File: rtl/snake_body_engine_if.sv
// Control, status and renderer-read bundle between the game controller and the snake body engine.
interface snake_body_engine_if #(
    parameter int MAX_LEN = 128,
    parameter int X_W     = 8,
    parameter int Y_W     = 7
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;

    logic           init;
    logic [1:0]     dir;
    logic           step;
    logic           grow;
    logic           step_ready;
    logic           busy;
    logic           step_done;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [1:0]     cur_dir;
    logic [LW-1:0]  length;
    logic           dead;
    logic           wall_hit;
    logic           self_hit;
    logic [IW-1:0]  rd_idx;
    logic [X_W-1:0] rd_x;
    logic [Y_W-1:0] rd_y;
    logic           rd_valid;

    modport master (
        output init, dir, step, grow, rd_idx,
        input  step_ready, busy, step_done, head_x, head_y, cur_dir, length,
               dead, wall_hit, self_hit, rd_x, rd_y, rd_valid
    );

    modport slave (
        input  init, dir, step, grow, rd_idx,
        output step_ready, busy, step_done, head_x, head_y, cur_dir, length,
               dead, wall_hit, self_hit, rd_x, rd_y, rd_valid
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body store and motion engine: circular segment buffer, move/grow, wall check and
// sequential self-collision scan, plus a registered indexed read port for the renderer.
module snake_body_engine #(
    parameter int MAX_LEN = 128,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int STEP    = 2,
    parameter int START_X = 80,
    parameter int START_Y = 60,
    parameter int XMIN    = 5,
    parameter int XMAX    = 153,
    parameter int YMIN    = 5,
    parameter int YMAX    = 107
) (
    input logic                clk,
    input logic                reset,
    snake_body_engine_if.slave bus
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic signed [X_W:0] STEP_X = (X_W+1)'(STEP);
    localparam logic signed [Y_W:0] STEP_Y = (Y_W+1)'(STEP);
    localparam logic signed [X_W:0] XMIN_S = (X_W+1)'(XMIN);
    localparam logic signed [X_W:0] XMAX_S = (X_W+1)'(XMAX);
    localparam logic signed [Y_W:0] YMIN_S = (Y_W+1)'(YMIN);
    localparam logic signed [Y_W:0] YMAX_S = (Y_W+1)'(YMAX);
    localparam logic [X_W-1:0]      START_XV = X_W'(START_X);
    localparam logic [Y_W-1:0]      START_YV = Y_W'(START_Y);
    localparam logic [LW-1:0]       LEN_MAX  = LW'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DEAD} state_t;

    state_t r_state, w_next_state;

    // The head lives in registers; slot r_head_ptr+k of the buffer holds segment k (k >= 1).
    logic [X_W-1:0] r_mem_x [MAX_LEN];
    logic [Y_W-1:0] r_mem_y [MAX_LEN];
    logic [X_W-1:0] r_head_x;
    logic [Y_W-1:0] r_head_y;
    logic [IW-1:0]  r_head_ptr;
    logic [LW-1:0]  r_length;
    logic [LW-1:0]  r_scan_idx;
    logic [1:0]     r_cur_dir;
    logic           r_dead, r_wall_hit, r_self_hit, r_step_done, r_hit;
    logic [X_W-1:0] r_rd_x;
    logic [Y_W-1:0] r_rd_y;
    logic           r_rd_valid;

    logic              w_accept, w_move, w_reverse, w_out_of_bounds, w_scan_last, w_match, w_rd_ok;
    logic [1:0]        w_eff_dir;
    logic signed [X_W:0] w_hx_s, w_nx;
    logic signed [Y_W:0] w_hy_s, w_ny;
    logic [IW-1:0]     w_scan_addr, w_rd_addr;
    logic [X_W-1:0]    w_rd_x;
    logic [Y_W-1:0]    w_rd_y;

    assign w_accept  = (r_state == S_IDLE) && !r_dead && bus.step && !bus.init;
    assign w_reverse = (bus.dir == (r_cur_dir ^ 2'b10)) && (r_length > LW'(1));
    assign w_eff_dir = w_reverse ? r_cur_dir : bus.dir;

    // Extra sign bit makes a move below zero compare as out of bounds instead of wrapping.
    assign w_hx_s = {1'b0, r_head_x};
    assign w_hy_s = {1'b0, r_head_y};

    always_comb begin
        w_nx = w_hx_s;
        w_ny = w_hy_s;
        case (w_eff_dir)
            DIR_UP:   w_ny = w_hy_s - STEP_Y;
            DIR_LEFT: w_nx = w_hx_s - STEP_X;
            DIR_DOWN: w_ny = w_hy_s + STEP_Y;
            default:  w_nx = w_hx_s + STEP_X;
        endcase
    end

    assign w_out_of_bounds = (w_nx < XMIN_S) || (w_nx > XMAX_S) || (w_ny < YMIN_S) || (w_ny > YMAX_S);
    assign w_move          = w_accept && !w_out_of_bounds;

    assign w_scan_addr = r_head_ptr + r_scan_idx[IW-1:0];
    assign w_scan_last = (r_scan_idx == r_length);
    assign w_match     = (r_mem_x[w_scan_addr] == r_head_x) && (r_mem_y[w_scan_addr] == r_head_y);

    assign w_rd_addr = r_head_ptr + bus.rd_idx;
    assign w_rd_ok   = ({1'b0, bus.rd_idx} < r_length) && (r_state != S_SCAN);
    assign w_rd_x    = (bus.rd_idx == '0) ? r_head_x : r_mem_x[w_rd_addr];
    assign w_rd_y    = (bus.rd_idx == '0) ? r_head_y : r_mem_y[w_rd_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.init) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next_state = w_out_of_bounds ? S_DEAD : S_SCAN;
                S_SCAN:  if (w_scan_last) w_next_state = r_hit ? S_DEAD : S_IDLE;
                S_DEAD:  w_next_state = S_DEAD;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: the segment store is deliberately not reset; nothing reads a slot before a step writes it.
    always_ff @(posedge clk) begin
        if (w_move) begin
            r_mem_x[r_head_ptr] <= r_head_x;
            r_mem_y[r_head_ptr] <= r_head_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_x    <= START_XV;
            r_head_y    <= START_YV;
            r_head_ptr  <= '0;
            r_length    <= LW'(1);
            r_scan_idx  <= '0;
            r_cur_dir   <= DIR_RIGHT;
            r_dead      <= 1'b0;
            r_wall_hit  <= 1'b0;
            r_self_hit  <= 1'b0;
            r_step_done <= 1'b0;
            r_hit       <= 1'b0;
            r_rd_x      <= '0;
            r_rd_y      <= '0;
            r_rd_valid  <= 1'b0;
        end else if (bus.init) begin
            r_head_x    <= START_XV;
            r_head_y    <= START_YV;
            r_head_ptr  <= '0;
            r_length    <= LW'(1);
            r_scan_idx  <= '0;
            r_cur_dir   <= DIR_RIGHT;
            r_dead      <= 1'b0;
            r_wall_hit  <= 1'b0;
            r_self_hit  <= 1'b0;
            r_step_done <= 1'b0;
            r_hit       <= 1'b0;
            r_rd_x      <= '0;
            r_rd_y      <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            r_rd_valid  <= w_rd_ok;
            r_rd_x      <= w_rd_ok ? w_rd_x : '0;
            r_rd_y      <= w_rd_ok ? w_rd_y : '0;
            if (w_accept) begin
                r_cur_dir <= w_eff_dir;
                if (w_out_of_bounds) begin
                    r_dead      <= 1'b1;
                    r_wall_hit  <= 1'b1;
                    r_step_done <= 1'b1;
                end else begin
                    r_head_x   <= w_nx[X_W-1:0];
                    r_head_y   <= w_ny[Y_W-1:0];
                    r_head_ptr <= r_head_ptr - IW'(1);
                    if (bus.grow && (r_length < LEN_MAX)) r_length <= r_length + LW'(1);
                    r_scan_idx <= LW'(1);
                    r_hit      <= 1'b0;
                end
            end else if (r_state == S_SCAN) begin
                if (w_scan_last) begin
                    r_step_done <= 1'b1;
                    r_self_hit  <= r_hit;
                    r_dead      <= r_hit;
                end else begin
                    r_scan_idx <= r_scan_idx + LW'(1);
                    if (w_match) r_hit <= 1'b1;
                end
            end
        end
    end

    assign bus.step_ready = (r_state == S_IDLE) && !r_dead;
    assign bus.busy       = (r_state == S_SCAN);
    assign bus.step_done  = r_step_done;
    assign bus.head_x     = r_head_x;
    assign bus.head_y     = r_head_y;
    assign bus.cur_dir    = r_cur_dir;
    assign bus.length     = r_length;
    assign bus.dead       = r_dead;
    assign bus.wall_hit   = r_wall_hit;
    assign bus.self_hit   = r_self_hit;
    assign bus.rd_x       = r_rd_x;
    assign bus.rd_y       = r_rd_y;
    assign bus.rd_valid   = r_rd_valid;
endmodule
